// File: rtl/fetch_unit_pkg.sv
// Shared constants, fetch-queue entry layout and RISC-V immediate decoders for the fetch unit.
package fetch_unit_pkg;

  localparam logic [6:0]  JALOP    = 7'b1101111;
  localparam logic [6:0]  BRANCHOP = 7'b1100011;
  localparam logic [6:0]  JALROP   = 7'b1100111;
  localparam logic [31:0] ZERO32   = 32'h0000_0000;
  localparam logic        TRUE     = 1'b1;
  localparam logic        FALSE    = 1'b0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] alt;
  } fetch_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO between the ICache response path and the decoder; head entry is presented combinationally.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     valid_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;
  assign valid_o = (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_i) tail_q <= tail_q + PW'(1);
        if (do_pop) head_q <= head_q + PW'(1);
        unique case ({push_i, do_pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && !flush_i && push_i) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding ICache requests, static JAL / BHT-predicted branch redirect,
// misprediction flush with drop of the in-flight response, and a decoupling fetch queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic [31:0] ROB_jump_PC_in,
  output logic        IC_req_out,
  output logic [31:0] IC_PC_out,
  input  logic        IC_flag_in,
  input  logic [31:0] IC_inst_in,
  input  logic        Dec_ready_in,
  output logic        Dec_inst_flag_out,
  output logic [31:0] Dec_inst_out,
  output logic [31:0] Dec_PC_out,
  output logic        Dec_jump_flag_out,
  output logic [31:0] Dec_jump_PC_out,
  input  logic        ROB_bp_flag_in,
  input  logic [31:0] ROB_bp_PC_in,
  input  logic        ROB_bp_taken_in
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);
  localparam int unsigned CW  = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]    pc_q, pc_d, next_pc;
  logic           out_q, out_d, drop_q, drop_d;
  logic [1:0]     bht_q [BHT_ENTRIES];
  logic [1:0]     lookup, bp_cnt, bp_next;
  logic [IDX-1:0] bp_idx;
  logic [CW-1:0]  count;
  logic           q_valid, push, pop;
  fetch_entry_t   push_entry, head;
  logic           unused_pc_bits;

  assign unused_pc_bits = ^{pc_q[31:IDX+2], pc_q[1:0], ROB_bp_PC_in[31:IDX+2], ROB_bp_PC_in[1:0]};

  assign IC_req_out = !out_q && !drop_q && (count < CW'(QUEUE_DEPTH)) && !jump_wrong && !rst && rdy;
  assign IC_PC_out  = pc_q;
  assign push       = IC_flag_in && !drop_q && !jump_wrong;
  assign pop        = q_valid && Dec_ready_in;
  assign lookup     = bht_q[pc_q[IDX+1:2]];

  // Prediction for the response being pushed this cycle.
  always_comb begin
    push_entry.inst = IC_inst_in;
    push_entry.pc   = pc_q;
    push_entry.pred = FALSE;
    push_entry.alt  = pc_q + 32'd4;
    next_pc         = pc_q + 32'd4;
    unique case (IC_inst_in[6:0])
      JALOP: begin
        next_pc         = pc_q + imm_j(IC_inst_in);
        push_entry.pred = TRUE;
      end
      BRANCHOP: begin
        if (lookup[1]) begin
          next_pc         = pc_q + imm_b(IC_inst_in);
          push_entry.pred = TRUE;
        end else begin
          push_entry.alt  = pc_q + imm_b(IC_inst_in);
        end
      end
      default: ;
    endcase
  end

  // A flush with a request in flight arms the drop flag so the stale response is swallowed.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (jump_wrong) begin
      pc_d   = ROB_jump_PC_in;
      out_d  = FALSE;
      drop_d = (out_q || drop_q) && !IC_flag_in;
    end else begin
      if (IC_flag_in) begin
        out_d = FALSE;
        if (drop_q) drop_d = FALSE;
        else        pc_d   = next_pc;
      end
      if (IC_req_out) out_d = TRUE;
    end
  end

  assign bp_idx = ROB_bp_PC_in[IDX+1:2];
  assign bp_cnt = bht_q[bp_idx];

  always_comb begin
    bp_next = bp_cnt;
    if (ROB_bp_taken_in) begin
      if (bp_cnt != 2'b11) bp_next = bp_cnt + 2'd1;
    end else begin
      if (bp_cnt != 2'b00) bp_next = bp_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= ZERO32;
      out_q  <= FALSE;
      drop_q <= FALSE;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else if (rdy) begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      if (ROB_bp_flag_in) bht_q[bp_idx] <= bp_next;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (rdy),
    .flush_i (jump_wrong),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head),
    .count_o (count),
    .valid_o (q_valid)
  );

  assign Dec_inst_flag_out = q_valid;
  assign Dec_inst_out      = head.inst;
  assign Dec_PC_out        = head.pc;
  assign Dec_jump_flag_out = head.pred;
  assign Dec_jump_PC_out   = head.alt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected decoder entries go into a scoreboard queue and a
// negedge monitor compares every entry the decoder accepts.
module tb_fetch_unit;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] JAL16 = 32'h0100_006F;
  localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] alt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, IC_flag_in, Dec_ready_in;
  logic        ROB_bp_flag_in, ROB_bp_taken_in;
  logic [31:0] ROB_jump_PC_in, IC_inst_in, ROB_bp_PC_in;
  logic        IC_req_out, Dec_inst_flag_out, Dec_jump_flag_out;
  logic [31:0] IC_PC_out, Dec_inst_out, Dec_PC_out, Dec_jump_PC_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic req_pending = 1'b0;
  logic [31:0] req_pc = 32'h0;

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .jump_wrong        (jump_wrong),
    .ROB_jump_PC_in    (ROB_jump_PC_in),
    .IC_req_out        (IC_req_out),
    .IC_PC_out         (IC_PC_out),
    .IC_flag_in        (IC_flag_in),
    .IC_inst_in        (IC_inst_in),
    .Dec_ready_in      (Dec_ready_in),
    .Dec_inst_flag_out (Dec_inst_flag_out),
    .Dec_inst_out      (Dec_inst_out),
    .Dec_PC_out        (Dec_PC_out),
    .Dec_jump_flag_out (Dec_jump_flag_out),
    .Dec_jump_PC_out   (Dec_jump_PC_out),
    .ROB_bp_flag_in    (ROB_bp_flag_in),
    .ROB_bp_PC_in      (ROB_bp_PC_in),
    .ROB_bp_taken_in   (ROB_bp_taken_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Records each request the DUT will issue at the following rising edge.
  always @(negedge clk) begin
    if (!rst && IC_req_out) begin
      req_pending = 1'b1;
      req_pc      = IC_PC_out;
    end
  end

  // Scoreboard monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rdy && !jump_wrong && Dec_inst_flag_out && Dec_ready_in) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL dec_unexpected: got pc %h inst %h with no entry expected", Dec_PC_out, Dec_inst_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({Dec_inst_out, Dec_PC_out, Dec_jump_flag_out, Dec_jump_PC_out} !== e) begin
          errors++;
          $display("FAIL dec_entry: got inst %h pc %h pred %b alt %h expected inst %h pc %h pred %b alt %h",
                   Dec_inst_out, Dec_PC_out, Dec_jump_flag_out, Dec_jump_PC_out, e.inst, e.pc, e.pred, e.alt);
        end
      end
    end
  end

  task automatic wait_req(output logic ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!req_pending && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    ok = req_pending;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no request expected one within 50 cycles");
    end
    req_pending = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] inst, input logic [31:0] pc, input logic pred,
                           input logic [31:0] alt, input logic chk_head);
    logic ok;
    wait_req(ok);
    if (ok) check("ic_pc", req_pc, pc);
    @(posedge clk); #1;
    IC_flag_in = 1'b1;
    IC_inst_in = inst;
    sbq.push_back('{inst, pc, pred, alt});
    @(negedge clk); #1;
    check("one_outstanding", 32'(IC_req_out), 32'd0);
    @(posedge clk); #1;
    IC_flag_in = 1'b0;
    if (chk_head) begin
      @(negedge clk); #1;
      check("head_valid", 32'(Dec_inst_flag_out), 32'd1);
      check("head_pc", Dec_PC_out, pc);
    end
  endtask

  task automatic bp_pulse(input logic [31:0] pc, input logic taken);
    ROB_bp_flag_in  = 1'b1;
    ROB_bp_PC_in    = pc;
    ROB_bp_taken_in = taken;
    @(negedge clk); #1;
    check("full_no_req", 32'(IC_req_out), 32'd0);
    check("full_valid", 32'(Dec_inst_flag_out), 32'd1);
    @(posedge clk); #1;
    ROB_bp_flag_in = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target, input logic bp_en, input logic [31:0] bp_pc,
                          input logic bp_taken);
    logic ok;
    wait_req(ok);
    @(posedge clk); #1;
    jump_wrong      = 1'b1;
    ROB_jump_PC_in  = target;
    ROB_bp_flag_in  = bp_en;
    ROB_bp_PC_in    = bp_pc;
    ROB_bp_taken_in = bp_taken;
    sbq.delete();
    @(negedge clk); #1;
    check("jw_no_req", 32'(IC_req_out), 32'd0);
    @(posedge clk); #1;
    jump_wrong     = 1'b0;
    ROB_bp_flag_in = 1'b0;
    IC_flag_in     = 1'b1;
    IC_inst_in     = JAL16;
    @(negedge clk); #1;
    check("flush_empty", 32'(Dec_inst_flag_out), 32'd0);
    check("drop_no_req", 32'(IC_req_out), 32'd0);
    @(posedge clk); #1;
    IC_flag_in = 1'b0;
    @(negedge clk); #1;
    check("dropped_resp", 32'(Dec_inst_flag_out), 32'd0);
    check("redirect_pc", IC_PC_out, target);
    check("req_after_drop", 32'(IC_req_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; IC_flag_in = 1'b0; Dec_ready_in = 1'b1;
    ROB_bp_flag_in = 1'b0; ROB_bp_taken_in = 1'b0;
    ROB_jump_PC_in = 32'h0; IC_inst_in = 32'h0; ROB_bp_PC_in = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req", 32'(IC_req_out), 32'd0);
    check("rst_valid", 32'(Dec_inst_flag_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_pending = 1'b0;

    // Sequential stream, JAL redirect, branch predicted not-taken from the reset counter.
    fetch_one(ADDI,  32'h00, 1'b0, 32'h04, 1'b1);
    fetch_one(ADDI,  32'h04, 1'b0, 32'h08, 1'b1);
    fetch_one(JAL16, 32'h08, 1'b1, 32'h0C, 1'b1);
    fetch_one(ADDI,  32'h18, 1'b0, 32'h1C, 1'b1);
    fetch_one(ADDI,  32'h1C, 1'b0, 32'h20, 1'b1);
    fetch_one(BEQM8, 32'h20, 1'b0, 32'h18, 1'b1);

    // rdy low for three cycles while the response is already on the bus.
    wait_req(ok);
    if (ok) check("ic_pc", req_pc, 32'h24);
    @(posedge clk); #1;
    rdy = 1'b0; IC_flag_in = 1'b1; IC_inst_in = ADDI;
    repeat (3) begin
      @(negedge clk); #1;
      check("stall_req", 32'(IC_req_out), 32'd0);
      check("stall_hold", 32'(Dec_inst_flag_out), 32'd0);
      check("stall_pc", IC_PC_out, 32'h24);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    sbq.push_back('{ADDI, 32'h24, 1'b0, 32'h28});
    @(posedge clk); #1;
    IC_flag_in = 1'b0;
    @(negedge clk); #1;
    check("head_pc", Dec_PC_out, 32'h24);

    // Decoder stalls until the queue fills; BHT trained meanwhile.
    @(posedge clk); #1;
    Dec_ready_in = 1'b0;
    for (int k = 0; k < 8; k++)
      fetch_one(ADDI, 32'h28 + 32'(4 * k), 1'b0, 32'h2C + 32'(4 * k), 1'b0);
    bp_pulse(32'h20, 1'b0);
    bp_pulse(32'h20, 1'b0);
    bp_pulse(32'h20, 1'b1);
    Dec_ready_in = 1'b1;
    @(negedge clk); #1;
    check("full_no_req", 32'(IC_req_out), 32'd0);
    @(posedge clk); #1;
    Dec_ready_in = 1'b0;
    @(negedge clk); #1;
    check("pop_reenables", 32'(IC_req_out), 32'd1);
    check("refill_pc", IC_PC_out, 32'h48);

    // Flush with a request in flight; BHT update rides along with the flush.
    redirect(32'h100, 1'b1, 32'h20, 1'b1);
    @(posedge clk); #1;
    Dec_ready_in = 1'b1;
    fetch_one(ADDI, 32'h100, 1'b0, 32'h104, 1'b1);
    redirect(32'h20, 1'b0, 32'h0, 1'b0);
    fetch_one(BEQM8, 32'h20, 1'b1, 32'h24, 1'b1);
    fetch_one(ADDI,  32'h18, 1'b0, 32'h1C, 1'b1);

    for (int n = 0; n < 20 && sbq.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
